port_arbiter: RTL
=================

PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesting input ports, fixed at 4 in this release.
REQ-002 The block SHALL have parameter DW, default 8, meaning the data width per port.
REQ-003 The block SHALL have parameter MAX_IDLE, default 16, meaning the number of idle cycles after which a held grant is revoked; legal range is 2..255.
REQ-004 Port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  meaning the asynchronous, active-low reset.
REQ-006 Port req  input  NREQ  meaning per-port request; bit i high means port i has a packet pending.
REQ-007 Port in_valid  input  NREQ  meaning per-port data valid.
REQ-008 Port in_last  input  NREQ  meaning per-port end-of-packet marker, qualified by in_valid.
REQ-009 Port in_data  input  NREQ*DW  meaning per-port data, with port i at bits [i*DW +: DW].
REQ-010 Port in_ready  output  NREQ  meaning per-port accept.
REQ-011 Port out_ready  input  1  meaning downstream accept.
REQ-012 Port out_valid, out_last  output  1 each  meaning the muxed valid and end-of-packet for the granted port.
REQ-013 Port out_data  output  DW  meaning the muxed data for the granted port.
REQ-014 Port gnt  output  NREQ  meaning the registered one-hot grant.
REQ-015 Port timeout  output  1  meaning a one-cycle pulse on grant revocation by idle timeout.

Function
REQ-016 The block SHALL implement two states: IDLE (gnt=0) and BUSY (exactly one gnt bit set).
REQ-017 In IDLE with req!=0, the block SHALL grant the first requesting port found scanning from rr_ptr upward modulo NREQ, and SHALL enter BUSY on the next edge, giving a request-to-grant latency of 1 cycle.
REQ-018 In IDLE with req=0, the block SHALL remain in IDLE with gnt=0.
REQ-019 In BUSY, out_valid, out_last and out_data SHALL be the in_valid, in_last and in_data of the granted port, combinationally.
REQ-020 In BUSY, in_ready[i] SHALL equal gnt[i] AND out_ready; in IDLE, in_ready SHALL be 0.
REQ-021 A transfer SHALL occur on any edge where out_valid and out_ready are both 1.
REQ-022 A transfer with out_last=1 SHALL clear gnt, set rr_ptr to (granted index + 1) mod NREQ, and return to IDLE; the next grant therefore comes no earlier than 2 cycles later (one bubble).
REQ-023 Deassertion of req by the granted port SHALL NOT release the grant; only a last-transfer, a timeout or reset SHALL release it.
REQ-024 The idle counter SHALL clear on grant, clear on every cycle with out_valid=1, and otherwise increment while in BUSY.
REQ-025 When the idle counter reaches MAX_IDLE, the block SHALL release the grant exactly as in REQ-022 and SHALL assert timeout for that one cycle.
REQ-026 Backpressure cycles with out_valid=1 and out_ready=0 SHALL NOT advance the idle counter.
REQ-027 If last-transfer and timeout conditions occur on the same edge, the last-transfer SHALL take precedence and timeout SHALL stay 0.
REQ-028 rr_ptr SHALL wrap from NREQ-1 to 0.

Reset
REQ-029 On reset low, the block SHALL asynchronously force gnt=0, state=IDLE, rr_ptr=0, idle counter=0 and timeout=0; out_valid, out_last and in_ready SHALL then read 0 and out_data SHALL read 0.
REQ-030 Reset asserted mid-packet SHALL abort the packet with no further transfers; after release, arbitration SHALL restart from port 0.

Verification
REQ-031 Scenario: after reset, req=4'b1010 -> gnt=4'b0010 one cycle later; a 3-beat packet with last on beat 3 -> gnt=0 the next cycle; req held -> gnt=4'b1000 after one bubble.
REQ-032 Scenario: req=4'b1111 held and every port sends 1-beat packets -> grant order 0,1,2,3,0, with one IDLE cycle between grants.
REQ-033 Scenario: granted port 2 with in_valid=0 for 16 cycles -> timeout pulses high for 1 cycle, gnt=0, and rr_ptr=3.
REQ-034 Scenario: granted port with out_ready=0 for 20 cycles while out_valid=1 -> no timeout, in_ready=0, and out_data stable.
REQ-035 Scenario: reset driven low mid-packet on port 1 -> gnt=0 immediately, with no clock edge required; after release with req=4'b0010 -> gnt=4'b0010.
REQ-036 Scenario: last beat accepted on the same edge the idle count would reach MAX_IDLE -> timeout=0 and a normal release.

Source files
------------

// File: rtl/port_arbiter.sv
// Round-robin packet arbiter: grants one of NREQ ports until its last beat
// is accepted or the grant sits idle for MAX_IDLE cycles.
module port_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int MAX_IDLE = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    in_valid,
  input  logic [NREQ-1:0]    in_last,
  input  logic [NREQ*DW-1:0] in_data,
  output logic [NREQ-1:0]    in_ready,
  input  logic               out_ready,
  output logic               out_valid,
  output logic               out_last,
  output logic [DW-1:0]      out_data,
  output logic [NREQ-1:0]    gnt,
  output logic               timeout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [CW-1:0] IDLE_LIMIT = CW'(MAX_IDLE - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NREQ - 1);

  logic [0:0]    state;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] idle_cnt;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] next_ptr;
  logic          xfer;
  logic          last_xfer;
  logic          idle_hit;

  // First requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (int'(rr_ptr) + k) % NREQ;
      if (!pick_found && req[c]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(c);
      end
    end
  end

  // gnt is zero in IDLE, so the AND-OR mux also yields all-zero outputs there.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        out_valid = in_valid[i];
        out_last  = in_last[i];
        out_data  = in_data[i*DW +: DW];
      end
    end
  end

  assign in_ready  = gnt & {NREQ{out_ready}};
  assign xfer      = out_valid & out_ready;
  assign last_xfer = xfer & out_last;
  assign idle_hit  = (state == ST_BUSY) && !out_valid && (idle_cnt == IDLE_LIMIT);
  assign next_ptr  = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

  // A stalled beat keeps out_valid high, so backpressure never counts as idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      rr_ptr   <= '0;
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            state    <= ST_BUSY;
            gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
            gnt_idx  <= pick_idx;
            idle_cnt <= '0;
          end
        end
        ST_BUSY: begin
          if (last_xfer) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            rr_ptr   <= next_ptr;
            idle_cnt <= '0;
          end else if (idle_hit) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            rr_ptr   <= next_ptr;
            idle_cnt <= '0;
            timeout  <= 1'b1;
          end else if (out_valid) begin
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule
